uart_line_adapter: RTL and testbench

//  Bit-level UART PHY that sits between a DUT's txd/rxd pins and the host-side byte bridge.
//  - RX path: deserialises the DUT's txd line into serial_out bytes (valid/ready) for the bridge.
//  - TX path: serialises serial_in bytes (valid/ready) from the bridge onto the DUT's rxd line.
//  - Frame format: 8N1 by default, LSB first, with a fixed clock-per-bit divisor.

---
 rtl/uart_line_adapter.sv | 366 ++++++++++++++++++++++++++++++++++++
 tb/tb_uart_line_adapter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_line_adapter.sv
// uart_line_adapter: bit-level UART PHY between a DUT's txd/rxd pins and a
// host-side byte bridge. RX deserialises uart_rxd_in into a one-byte holding
// register; TX serialises accepted bytes onto uart_txd_out. Frames are LSB first,
// 8 data bits, STOP_BITS stop bits on TX, one stop bit checked on RX.
//
// Optional feature: define UART_LINE_ADAPTER_PARITY_EN to add an even parity
// bit after the data bits (TX inserts it, RX checks it and flags frame_err).
//
// Handshakes (both byte ports): a transfer happens on the rising clock edge
// where valid && ready are both 1. serial_in_ready is registered and is only 1
// while the TX FSM is idle. serial_out_valid stays high until it is consumed.
//
// tx_state_dbg / rx_state_dbg expose the encoded FSM states for observation.
module uart_line_adapter #(
    parameter int DIV       = 16,
    parameter int STOP_BITS = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       uart_rxd_in,
    output logic       uart_txd_out,
    output logic       serial_out_valid,
    input  logic       serial_out_ready,
    output logic [7:0] serial_out_bits,
    input  logic       serial_in_valid,
    output logic       serial_in_ready,
    input  logic [7:0] serial_in_bits,
    output logic       frame_err,
    output logic       overrun,
    output logic [2:0] tx_state_dbg,
    output logic [2:0] rx_state_dbg
);

    // Counters are sized for the longest interval (the TX stop period).
    localparam int CW = $clog2(DIV * STOP_BITS) + 1;
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] BIT_LOAD  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] STOP_LOAD = CW'(DIV * STOP_BITS - 1);

`ifdef UART_LINE_ADAPTER_PARITY_EN
    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;
`else
    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_START = 3'd1,
        TX_DATA  = 3'd2,
        TX_STOP  = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_STOP  = 3'd4
    } rx_state_t;
`endif

    // ------------------------------------------------------------------
    // TX path
    // ------------------------------------------------------------------
    tx_state_t      tx_state, tx_state_n;
    logic [CW-1:0]  tx_cnt, tx_cnt_n;
    logic [2:0]     tx_bit, tx_bit_n;
    logic [7:0]     tx_shift, tx_shift_n;
    logic           txd_n;
    logic           tx_ready_n;
    logic           tx_accept;
`ifdef UART_LINE_ADAPTER_PARITY_EN
    logic           tx_par, tx_par_n;
`endif

    assign tx_accept    = serial_in_valid && serial_in_ready;
    assign tx_state_dbg = tx_state;

    // TX next-state: count each level down to zero, then advance.
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
`ifdef UART_LINE_ADAPTER_PARITY_EN
        tx_par_n   = tx_par;
`endif
        case (tx_state)
            TX_IDLE: begin
                if (tx_accept) begin
                    tx_state_n = TX_START;
                    tx_cnt_n   = BIT_LOAD;
                    tx_shift_n = serial_in_bits;
`ifdef UART_LINE_ADAPTER_PARITY_EN
                    tx_par_n   = ^serial_in_bits;
`endif
                end
            end
            TX_START: begin
                if (tx_cnt == '0) begin
                    tx_state_n = TX_DATA;
                    tx_cnt_n   = BIT_LOAD;
                    tx_bit_n   = 3'd0;
                end else begin
                    tx_cnt_n = tx_cnt - CNT_ONE;
                end
            end
            TX_DATA: begin
                if (tx_cnt == '0) begin
                    if (tx_bit == 3'd7) begin
`ifdef UART_LINE_ADAPTER_PARITY_EN
                        tx_state_n = TX_PARITY;
                        tx_cnt_n   = BIT_LOAD;
`else
                        tx_state_n = TX_STOP;
                        tx_cnt_n   = STOP_LOAD;
`endif
                    end else begin
                        tx_bit_n   = tx_bit + 3'd1;
                        tx_shift_n = {1'b0, tx_shift[7:1]};
                        tx_cnt_n   = BIT_LOAD;
                    end
                end else begin
                    tx_cnt_n = tx_cnt - CNT_ONE;
                end
            end
`ifdef UART_LINE_ADAPTER_PARITY_EN
            TX_PARITY: begin
                if (tx_cnt == '0) begin
                    tx_state_n = TX_STOP;
                    tx_cnt_n   = STOP_LOAD;
                end else begin
                    tx_cnt_n = tx_cnt - CNT_ONE;
                end
            end
`endif
            TX_STOP: begin
                if (tx_cnt == '0) begin
                    tx_state_n = TX_IDLE;
                end else begin
                    tx_cnt_n = tx_cnt - CNT_ONE;
                end
            end
            default: begin
                tx_state_n = TX_IDLE;
                tx_cnt_n   = '0;
            end
        endcase

        // Line level and ready are registered from the upcoming state so the
        // pin changes on the same edge as the state.
        case (tx_state_n)
            TX_START: txd_n = 1'b0;
            TX_DATA:  txd_n = tx_shift_n[0];
`ifdef UART_LINE_ADAPTER_PARITY_EN
            TX_PARITY: txd_n = tx_par_n;
`endif
            default:  txd_n = 1'b1;
        endcase
        tx_ready_n = (tx_state_n == TX_IDLE);
    end

    // TX state and registered pin/ready outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_state        <= TX_IDLE;
            tx_cnt          <= '0;
            tx_bit          <= 3'd0;
            tx_shift        <= 8'h00;
            uart_txd_out    <= 1'b1;
            serial_in_ready <= 1'b0;
`ifdef UART_LINE_ADAPTER_PARITY_EN
            tx_par          <= 1'b0;
`endif
        end else begin
            tx_state        <= tx_state_n;
            tx_cnt          <= tx_cnt_n;
            tx_bit          <= tx_bit_n;
            tx_shift        <= tx_shift_n;
            uart_txd_out    <= txd_n;
            serial_in_ready <= tx_ready_n;
`ifdef UART_LINE_ADAPTER_PARITY_EN
            tx_par          <= tx_par_n;
`endif
        end
    end

    // ------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------
    logic           rx_meta, rx_sync;
    rx_state_t      rx_state, rx_state_n;
    logic [CW-1:0]  rx_cnt, rx_cnt_n;
    logic [2:0]     rx_bit, rx_bit_n;
    logic [7:0]     rx_shift, rx_shift_n;
    logic           rx_armed, rx_armed_n;
    logic           rx_load;
    logic           frame_err_n;
    logic           overrun_n;
    logic           rx_parity_ok;
`ifdef UART_LINE_ADAPTER_PARITY_EN
    logic           rx_par_err, rx_par_err_n;
    assign rx_parity_ok = !rx_par_err;
`else
    assign rx_parity_ok = 1'b1;
`endif

    assign rx_state_dbg = rx_state;

    // Two-flop synchroniser for the asynchronous line; idles high.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= uart_rxd_in;
            rx_sync <= rx_meta;
        end
    end

    // RX next-state: detect start, sample each bit mid-way, judge the stop bit.
    always_comb begin
        rx_state_n  = rx_state;
        rx_cnt_n    = rx_cnt;
        rx_bit_n    = rx_bit;
        rx_shift_n  = rx_shift;
        rx_armed_n  = rx_armed;
        rx_load     = 1'b0;
        frame_err_n = 1'b0;
        overrun_n   = 1'b0;
`ifdef UART_LINE_ADAPTER_PARITY_EN
        rx_par_err_n = rx_par_err;
`endif
        case (rx_state)
            RX_IDLE: begin
                // After a break the line must return high before a new start
                // edge is trusted.
                if (!rx_armed) begin
                    if (rx_sync) begin
                        rx_armed_n = 1'b1;
                    end
                end else if (!rx_sync) begin
                    rx_state_n = RX_START;
                    rx_cnt_n   = HALF_LOAD;
                end
            end
            RX_START: begin
                if (rx_cnt == '0) begin
                    if (!rx_sync) begin
                        rx_state_n = RX_DATA;
                        rx_cnt_n   = BIT_LOAD;
                        rx_bit_n   = 3'd0;
`ifdef UART_LINE_ADAPTER_PARITY_EN
                        rx_par_err_n = 1'b0;
`endif
                    end else begin
                        rx_state_n = RX_IDLE;
                    end
                end else begin
                    rx_cnt_n = rx_cnt - CNT_ONE;
                end
            end
            RX_DATA: begin
                if (rx_cnt == '0) begin
                    rx_shift_n = {rx_sync, rx_shift[7:1]};
                    rx_cnt_n   = BIT_LOAD;
                    if (rx_bit == 3'd7) begin
`ifdef UART_LINE_ADAPTER_PARITY_EN
                        rx_state_n = RX_PARITY;
`else
                        rx_state_n = RX_STOP;
`endif
                    end else begin
                        rx_bit_n = rx_bit + 3'd1;
                    end
                end else begin
                    rx_cnt_n = rx_cnt - CNT_ONE;
                end
            end
`ifdef UART_LINE_ADAPTER_PARITY_EN
            RX_PARITY: begin
                if (rx_cnt == '0) begin
                    rx_par_err_n = rx_sync ^ (^rx_shift);
                    rx_state_n   = RX_STOP;
                    rx_cnt_n     = BIT_LOAD;
                end else begin
                    rx_cnt_n = rx_cnt - CNT_ONE;
                end
            end
`endif
            RX_STOP: begin
                if (rx_cnt == '0) begin
                    rx_state_n = RX_IDLE;
                    if (!rx_sync) begin
                        frame_err_n = 1'b1;
                        rx_armed_n  = 1'b0;
                    end else if (!rx_parity_ok) begin
                        frame_err_n = 1'b1;
                    end else if (serial_out_valid && !serial_out_ready) begin
                        overrun_n = 1'b1;
                    end else begin
                        rx_load = 1'b1;
                    end
                end else begin
                    rx_cnt_n = rx_cnt - CNT_ONE;
                end
            end
            default: begin
                rx_state_n = RX_IDLE;
                rx_cnt_n   = '0;
            end
        endcase
    end

    // RX state, counters and error pulses.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_state  <= RX_IDLE;
            rx_cnt    <= '0;
            rx_bit    <= 3'd0;
            rx_shift  <= 8'h00;
            rx_armed  <= 1'b1;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_LINE_ADAPTER_PARITY_EN
            rx_par_err <= 1'b0;
`endif
        end else begin
            rx_state  <= rx_state_n;
            rx_cnt    <= rx_cnt_n;
            rx_bit    <= rx_bit_n;
            rx_shift  <= rx_shift_n;
            rx_armed  <= rx_armed_n;
            frame_err <= frame_err_n;
            overrun   <= overrun_n;
`ifdef UART_LINE_ADAPTER_PARITY_EN
            rx_par_err <= rx_par_err_n;
`endif
        end
    end

    // Holding register: a new byte wins over a same-edge consume.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            serial_out_valid <= 1'b0;
            serial_out_bits  <= 8'h00;
        end else if (rx_load) begin
            serial_out_valid <= 1'b1;
            serial_out_bits  <= rx_shift;
        end else if (serial_out_valid && serial_out_ready) begin
            serial_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_line_adapter.sv
// Testbench for uart_line_adapter (DIV=4, STOP_BITS=1). Inputs are driven and
// outputs sampled on the falling clock edge. Expected TX line levels and RX
// bytes/error counts come from a frame-level model of the UART format.
module tb_uart_line_adapter;

    localparam int DIV = 4;
    localparam int SB  = 1;
`ifdef UART_LINE_ADAPTER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME = (10 + PAR + SB - 1) * DIV;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       uart_rxd_in = 1'b1;
    logic       uart_txd_out;
    logic       serial_out_valid;
    logic       serial_out_ready = 1'b0;
    logic [7:0] serial_out_bits;
    logic       serial_in_valid = 1'b0;
    logic       serial_in_ready;
    logic [7:0] serial_in_bits = 8'h00;
    logic       frame_err;
    logic       overrun;
    logic [2:0] tx_state_dbg;
    logic [2:0] rx_state_dbg;

    int errors = 0;
    int checks = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int exp_fe = 0;
    int exp_ov = 0;
    logic [7:0] exp_q[$];

    uart_line_adapter #(.DIV(DIV), .STOP_BITS(SB)) dut (
        .clock            (clock),
        .reset            (reset),
        .uart_rxd_in      (uart_rxd_in),
        .uart_txd_out     (uart_txd_out),
        .serial_out_valid (serial_out_valid),
        .serial_out_ready (serial_out_ready),
        .serial_out_bits  (serial_out_bits),
        .serial_in_valid  (serial_in_valid),
        .serial_in_ready  (serial_in_ready),
        .serial_in_bits   (serial_in_bits),
        .frame_err        (frame_err),
        .overrun          (overrun),
        .tx_state_dbg     (tx_state_dbg),
        .rx_state_dbg     (rx_state_dbg)
    );

    // Clock and error-pulse counters.
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (reset) begin
            if (frame_err === 1'b1) fe_cnt++;
            if (overrun === 1'b1) ov_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    // Even parity: number of ones in the byte, modulo 2.
    function automatic logic par_of(input logic [7:0] d);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) n += int'(d[i]);
        return (n % 2) == 1;
    endfunction

    // Expected txd level c clocks after the accept edge.
    function automatic logic tx_level(input logic [7:0] d, input int c);
        int k;
        k = c / DIV;
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (PAR == 1 && k == 9) return par_of(d);
        return 1'b1;
    endfunction

    // Driver: offer one byte on the TX port and check every clock of its frame.
    task automatic tx_frame(input logic [7:0] data, input bit keep_valid,
                            input string name, output int waited);
        int bad;
        serial_in_bits  = data;
        serial_in_valid = 1'b1;
        waited = 0;
        while (serial_in_ready !== 1'b1 && waited < 200) begin
            @(negedge clock);
            waited++;
        end
        checks++;
        if (serial_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready_timeout: ready=%b required 1", name, serial_in_ready);
            serial_in_valid = 1'b0;
            return;
        end
        @(negedge clock);
        if (!keep_valid) serial_in_valid = 1'b0;
        bad = 0;
        for (int c = 0; c < FRAME; c++) begin
            checks++;
            if (uart_txd_out !== tx_level(data, c) || serial_in_ready !== 1'b0) begin
                errors++;
                if (bad < 4)
                    $display("FAIL %s_frame clk %0d: txd=%b ready=%b required txd=%b ready=0",
                             name, c, uart_txd_out, serial_in_ready, tx_level(data, c));
                bad++;
            end
            @(negedge clock);
        end
        checks++;
        if (serial_in_ready !== 1'b1 || uart_txd_out !== 1'b1) begin
            errors++;
            $display("FAIL %s_end_idle: ready=%b txd=%b required 1 1", name, serial_in_ready, uart_txd_out);
        end
    endtask

    // Driver: put one frame on the RX line and update the model.
    task automatic rx_drive(input logic [7:0] data, input bit stop_ok,
                            input bit par_ok, input int break_len);
        logic lv[$];
        bit good;
        lv.push_back(1'b0);
        for (int i = 0; i < 8; i++) lv.push_back(data[i]);
        if (PAR == 1) lv.push_back(par_of(data) ^ !par_ok);
        lv.push_back(stop_ok);
        foreach (lv[i]) begin
            uart_rxd_in = lv[i];
            repeat (DIV) @(negedge clock);
        end
        if (!stop_ok) repeat (break_len) @(negedge clock);
        uart_rxd_in = 1'b1;
        repeat (6) @(negedge clock);
        good = stop_ok && (PAR == 0 || par_ok);
        if (good) begin
            if (exp_q.size() == 0) exp_q.push_back(data);
            else exp_ov++;
        end else begin
            exp_fe++;
        end
    endtask

    // Scoreboard: the holding register must present the oldest expected byte.
    task automatic rx_expect(input string name);
        int n;
        logic [7:0] exp;
        n = 0;
        while (serial_out_valid !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s_model: no byte expected but consume requested", name);
            return;
        end
        exp = exp_q.pop_front();
        if (serial_out_valid !== 1'b1 || serial_out_bits !== exp) begin
            errors++;
            $display("FAIL %s_byte: valid=%b bits=%h required valid=1 bits=%h",
                     name, serial_out_valid, serial_out_bits, exp);
        end
        serial_out_ready = 1'b1;
        @(negedge clock);
        serial_out_ready = 1'b0;
        checks++;
        if (serial_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_cleared: valid=%b required 0", name, serial_out_valid);
        end
    endtask

    task automatic check_counts(input string name);
        checks++;
        if (fe_cnt !== exp_fe || ov_cnt !== exp_ov) begin
            errors++;
            $display("FAIL %s_pulses: frame_err=%0d overrun=%0d required %0d %0d",
                     name, fe_cnt, ov_cnt, exp_fe, exp_ov);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        uart_rxd_in = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if ({uart_txd_out, serial_in_ready, serial_out_valid, frame_err, overrun} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_ctrl: txd,ready,valid,fe,ov=%b required 10000",
                     {uart_txd_out, serial_in_ready, serial_out_valid, frame_err, overrun});
        end
        checks++;
        if (serial_out_bits !== 8'h00) begin
            errors++;
            $display("FAIL reset_bits: bits=%h required 00", serial_out_bits);
        end
    endtask

    task automatic test_tx_after_reset();
        int w;
        reset = 1'b1;
        tx_frame(8'hA5, 1'b0, "tx_a5", w);
        checks++;
        if (w !== 1) begin
            errors++;
            $display("FAIL tx_ready_after_reset: ready after %0d clocks required 1", w);
        end
    endtask

    task automatic test_tx_idle();
        int bad;
        bad = 0;
        serial_in_valid = 1'b0;
        repeat (8) begin
            @(negedge clock);
            if (uart_txd_out !== 1'b1 || serial_in_ready !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL tx_idle_hold: %0d idle clocks with txd/ready not 1, required 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        int w;
        logic [7:0] d;
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom_range(0, 255));
            tx_frame(d, 1'b1, "tx_b2b", w);
            if (i > 0) begin
                checks++;
                if (w !== 0) begin
                    errors++;
                    $display("FAIL tx_b2b_gap: frame %0d waited %0d clocks required 0", i, w);
                end
            end
        end
        serial_in_valid = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_rx_hold();
        int bad;
        rx_drive(8'h3C, 1'b1, 1'b1, 0);
        bad = 0;
        repeat (10) begin
            @(negedge clock);
            if (serial_out_valid !== 1'b1 || serial_out_bits !== 8'h3C) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rx_hold: %0d clocks without valid=1 bits=3c, required 0", bad);
        end
        rx_expect("rx_3c");
        check_counts("rx_hold");
    endtask

    task automatic test_rx_glitch();
        uart_rxd_in = 1'b0;
        @(negedge clock);
        uart_rxd_in = 1'b1;
        repeat (10) @(negedge clock);
        checks++;
        if (serial_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rx_glitch_valid: valid=%b required 0", serial_out_valid);
        end
        check_counts("rx_glitch");
        rx_drive(8'h81, 1'b1, 1'b1, 0);
        rx_expect("rx_81");
    endtask

    task automatic test_rx_break();
        rx_drive(8'h55, 1'b0, 1'b1, 20);
        check_counts("rx_break");
        checks++;
        if (serial_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rx_break_valid: valid=%b required 0", serial_out_valid);
        end
        rx_drive(8'h12, 1'b1, 1'b1, 0);
        rx_expect("rx_12");
        check_counts("rx_after_break");
    endtask

    task automatic test_rx_overrun();
        rx_drive(8'h11, 1'b1, 1'b1, 0);
        rx_drive(8'h22, 1'b1, 1'b1, 0);
        check_counts("rx_overrun");
        rx_expect("rx_11_kept");
        repeat (4) @(negedge clock);
        checks++;
        if (serial_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rx_overrun_dropped: valid=%b required 0", serial_out_valid);
        end
    endtask

    task automatic test_rx_random();
        logic [7:0] d;
        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom_range(0, 255));
            rx_drive(d, 1'b1, 1'b1, 0);
            rx_expect("rx_random");
        end
        check_counts("rx_random");
    endtask

    task automatic test_reset_mid_tx();
        int n;
        int w;
        serial_in_bits  = 8'hFF;
        serial_in_valid = 1'b1;
        n = 0;
        while (serial_in_ready !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        serial_in_valid = 1'b0;
        repeat (DIV + 5) @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (uart_txd_out !== 1'b1 || serial_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_tx: txd=%b ready=%b required 1 0", uart_txd_out, serial_in_ready);
        end
        exp_q.delete();
        repeat (3) @(negedge clock);
        reset = 1'b1;
        tx_frame(8'h0F, 1'b0, "tx_0f_after_reset", w);
        checks++;
        if (w !== 1) begin
            errors++;
            $display("FAIL reset_mid_tx_ready: ready after %0d clocks required 1", w);
        end
    endtask

`ifdef UART_LINE_ADAPTER_PARITY_EN
    task automatic test_parity();
        int w;
        logic [7:0] d;
        tx_frame(8'h07, 1'b0, "tx_par_07", w);
        d = 8'($urandom_range(0, 255));
        rx_drive(d, 1'b1, 1'b0, 0);
        check_counts("rx_bad_parity");
        checks++;
        if (serial_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rx_bad_parity_valid: valid=%b required 0", serial_out_valid);
        end
        d = 8'($urandom_range(0, 255));
        rx_drive(d, 1'b1, 1'b1, 0);
        rx_expect("rx_good_parity");
    endtask
`endif

    initial begin
        test_reset();
        test_tx_after_reset();
        test_tx_idle();
        test_back_to_back();
        test_rx_hold();
        test_rx_glitch();
        test_rx_break();
        test_rx_overrun();
        test_rx_random();
        test_reset_mid_tx();
`ifdef UART_LINE_ADAPTER_PARITY_EN
        test_parity();
`endif
        check_counts("final");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
